// File: rtl/uart_rx_pkg.sv
// Shared types for the UART receive frame controller.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int MIN_PRESCALE = 4;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and three-sample majority vote
// around the middle of each bit period.
module uart_rx_sampler #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      rx_clk,
  input  logic                      res_n,
  input  logic                      start,
  input  logic                      run,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      s_data_in,
  output logic                      vote,
  output logic                      vote_valid,
  output logic                      bit_end
);

  localparam int PW = PRESCALE_WIDTH;

  logic [PW-1:0] edge_cnt;
  logic [PW-1:0] half;
  logic          s0;
  logic          s1;

  assign half       = prescale >> 1;
  assign bit_end    = run && (edge_cnt == prescale - PW'(1));
  assign vote_valid = run && (edge_cnt == half + PW'(1));
  assign vote       = (s0 & s1) | (s0 & s_data_in) | (s1 & s_data_in);

  // start wins so a detection right after a frame ends restarts at edge 1
  always_ff @(posedge rx_clk or negedge res_n) begin
    if (!res_n) begin
      edge_cnt <= '0;
      s0       <= 1'b0;
      s1       <= 1'b0;
    end else begin
      if (start) begin
        edge_cnt <= PW'(1);
      end else if (run) begin
        edge_cnt <= bit_end ? '0 : edge_cnt + PW'(1);
      end else begin
        edge_cnt <= '0;
      end
      if (run && (edge_cnt == half - PW'(1))) begin
        s0 <= s_data_in;
      end
      if (run && (edge_cnt == half)) begin
        s1 <= s_data_in;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detect, bit sequencing,
// parity/stop checks and per-frame result pulses.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                          rx_clk,
  input  logic                          res_n,
  input  logic [PRESCALE_WIDTH-1:0]     prescale_in,
  input  logic                          s_data_in,
  input  logic                          par_en_in,
  input  logic                          par_typ_in,
  output logic                          sampled_bit_out,
  output logic                          shift_en_out,
  output logic [$clog2(DATA_WIDTH)-1:0] bit_idx_out,
  output logic                          busy_out,
  output logic                          data_valid_out,
  output logic                          parity_error_out,
  output logic                          stop_error_out
);

  localparam int IW = $clog2(DATA_WIDTH);
  localparam int PW = PRESCALE_WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);
  localparam logic [PW-1:0] MIN_P    = PW'(MIN_PRESCALE);

  rx_state_e     state_q;
  rx_state_e     state_d;
  logic [PW-1:0] pre_even;
  logic [PW-1:0] pre_eff;
  logic [PW-1:0] p_q;
  logic          par_en_q;
  logic          par_typ_q;
  logic          par_acc_q;
  logic          par_err_q;
  logic          armed_q;
  logic [IW-1:0] bit_idx_q;
  logic          start_det;
  logic          run;
  logic          vote;
  logic          vote_valid;
  logic          bit_end;
  logic          shift_d;
  logic          dv_d;
  logic          pe_d;
  logic          se_d;

  // odd ratios round down, tiny ratios clamp to the minimum
  assign pre_even  = prescale_in & ~PW'(1);
  assign pre_eff   = (pre_even < MIN_P) ? MIN_P : pre_even;
  assign run       = (state_q != IDLE);
  assign start_det = (state_q == IDLE) && !s_data_in && armed_q;

  uart_rx_sampler #(
    .PRESCALE_WIDTH(PW)
  ) u_sampler (
    .rx_clk    (rx_clk),
    .res_n     (res_n),
    .start     (start_det),
    .run       (run),
    .prescale  (p_q),
    .s_data_in (s_data_in),
    .vote      (vote),
    .vote_valid(vote_valid),
    .bit_end   (bit_end)
  );

  always_comb begin
    state_d = state_q;
    shift_d = 1'b0;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    se_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_det) state_d = START;
      end
      START: begin
        if (vote_valid && vote) state_d = IDLE;
        else if (bit_end) state_d = DATA;
      end
      DATA: begin
        shift_d = vote_valid;
        if (bit_end && (bit_idx_q == LAST_IDX)) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        // leave at the vote so the next start edge is caught early
        if (vote_valid) begin
          state_d = IDLE;
          dv_d    = vote && !par_err_q;
          pe_d    = par_err_q;
          se_d    = !vote;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge rx_clk or negedge res_n) begin
    if (!res_n) begin
      p_q              <= MIN_P;
      par_en_q         <= 1'b0;
      par_typ_q        <= 1'b0;
      par_acc_q        <= 1'b0;
      par_err_q        <= 1'b0;
      armed_q          <= 1'b1;
      bit_idx_q        <= '0;
      sampled_bit_out  <= 1'b0;
      shift_en_out     <= 1'b0;
      bit_idx_out      <= '0;
      busy_out         <= 1'b0;
      data_valid_out   <= 1'b0;
      parity_error_out <= 1'b0;
      stop_error_out   <= 1'b0;
    end else begin
      busy_out         <= (state_d != IDLE);
      shift_en_out     <= shift_d;
      data_valid_out   <= dv_d;
      parity_error_out <= pe_d;
      stop_error_out   <= se_d;
      if (start_det) begin
        p_q       <= pre_eff;
        par_en_q  <= par_en_in;
        par_typ_q <= par_typ_in;
        par_acc_q <= 1'b0;
        par_err_q <= 1'b0;
      end
      if (shift_d) begin
        sampled_bit_out <= vote;
        bit_idx_out     <= bit_idx_q;
        par_acc_q       <= par_acc_q ^ vote;
      end
      if ((state_q == START) && bit_end) begin
        bit_idx_q <= '0;
      end else if ((state_q == DATA) && bit_end
                   && (bit_idx_q != LAST_IDX)) begin
        bit_idx_q <= bit_idx_q + IW'(1);
      end
      if ((state_q == PARITY) && vote_valid) begin
        par_err_q <= vote != (par_acc_q ^ par_typ_q);
      end
      // a bad stop keeps a stuck-low line from retriggering
      if (se_d) begin
        armed_q <= 1'b0;
      end else if (s_data_in) begin
        armed_q <= 1'b1;
      end
    end
  end

endmodule
